// File: rtl/tlb_miss_arbiter_pkg.sv
// Shared widths and payload types for the L1-TLB miss path into the shared TLB.
package tlb_miss_arbiter_pkg;

  localparam int unsigned VPN_WIDTH    = 27;
  localparam int unsigned PPN_WIDTH    = 44;
  localparam int unsigned ASID_WIDTH   = 16;
  localparam int unsigned PGSIZE_WIDTH = 2;

  typedef enum logic {
    SRC_ITLB = 1'b0,
    SRC_DTLB = 1'b1
  } miss_src_e;

  typedef enum logic [PGSIZE_WIDTH-1:0] {
    PG_4K = 2'd0,
    PG_2M = 2'd1,
    PG_1G = 2'd2
  } pg_size_e;

  typedef struct packed {
    logic [VPN_WIDTH-1:0]  vpn;
    logic [ASID_WIDTH-1:0] asid;
    miss_src_e             src;
  } tlb_miss_req_t;

  typedef struct packed {
    logic [PPN_WIDTH-1:0] ppn;
    pg_size_e             pgsize;
    logic                 fault;
  } tlb_resp_t;

  // The source that is not s; used to break ties against the last winner.
  function automatic miss_src_e other_src(input miss_src_e s);
    miss_src_e o;
    if (s == SRC_ITLB) o = SRC_DTLB;
    else               o = SRC_ITLB;
    return o;
  endfunction

endpackage

// File: rtl/tlb_miss_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between ITLB and DTLB misses; the last winner
// loses the next tie and the history only moves on an accepted grant.
module tlb_miss_arbiter_rr_arb2
  import tlb_miss_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      itlb_valid,
  input  logic      dtlb_valid,
  input  logic      handshake,
  output logic      grant_valid_c,
  output miss_src_e grant_src_c
);

  miss_src_e rr_last_q;

  always_comb begin
    grant_valid_c = itlb_valid | dtlb_valid;
    grant_src_c   = SRC_ITLB;
    if (itlb_valid && dtlb_valid) grant_src_c = other_src(rr_last_q);
    else if (dtlb_valid)          grant_src_c = SRC_DTLB;
  end

  // Reset to ITLB so that the DTLB wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)            rr_last_q <= SRC_ITLB;
    else if (handshake) rr_last_q <= grant_src_c;
  end

endmodule

// File: rtl/tlb_miss_arbiter.sv
// Arbitrates ITLB/DTLB misses into one outstanding shared-TLB lookup and routes
// the result back. Define TLB_MISS_TIMEOUT_EN to add the lookup watchdog.
module tlb_miss_arbiter
  import tlb_miss_arbiter_pkg::*;
#(
  parameter int unsigned VPN_W  = VPN_WIDTH,
  parameter int unsigned PPN_W  = PPN_WIDTH,
  parameter int unsigned ASID_W = ASID_WIDTH
`ifdef TLB_MISS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              itlb_miss_valid_i,
  output logic              itlb_miss_ready_o,
  input  logic [VPN_W-1:0]  itlb_vpn_i,
  input  logic [ASID_W-1:0] itlb_asid_i,
  input  logic              dtlb_miss_valid_i,
  output logic              dtlb_miss_ready_o,
  input  logic [VPN_W-1:0]  dtlb_vpn_i,
  input  logic [ASID_W-1:0] dtlb_asid_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [VPN_W-1:0]  req_vpn_o,
  output logic [ASID_W-1:0] req_asid_o,
  input  logic              resp_valid_i,
  input  logic [PPN_W-1:0]  resp_ppn_i,
  input  logic [1:0]        resp_pgsize_i,
  input  logic              resp_fault_i,
  output logic              itlb_resp_valid_o,
  output logic              dtlb_resp_valid_o,
  output logic [PPN_W-1:0]  resp_ppn_o,
  output logic [1:0]        resp_pgsize_o,
  output logic              resp_fault_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  tlb_miss_req_t req_q, req_d;
  tlb_resp_t     resp_q, resp_d;
  logic          req_valid_q, req_valid_d;
  logic          drop_q, drop_d;
  logic          itlb_pulse_q, itlb_pulse_d;
  logic          dtlb_pulse_q, dtlb_pulse_d;

  logic      grant_valid_c;
  miss_src_e grant_src_c;
  logic      handshake_c;
  logic      resp_live_c;
  logic      timeout_c;

`ifdef TLB_MISS_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]  stale_q, stale_d;

  // Responses owed to timed-out lookups are swallowed until the debt is paid.
  assign resp_live_c = resp_valid_i && (stale_q == 2'd0);
  assign timeout_c   = (state_q == ST_WAIT) && !resp_live_c &&
                       ((wd_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES - 1));
`else
  assign resp_live_c = resp_valid_i;
  assign timeout_c   = 1'b0;
`endif

  tlb_miss_arbiter_rr_arb2 u_rr_arb2 (
    .clk           (clk_i),
    .rst           (rst_i),
    .itlb_valid    (itlb_miss_valid_i),
    .dtlb_valid    (dtlb_miss_valid_i),
    .handshake     (handshake_c),
    .grant_valid_c (grant_valid_c),
    .grant_src_c   (grant_src_c)
  );

  assign handshake_c       = (state_q == ST_IDLE) && grant_valid_c;
  assign itlb_miss_ready_o = handshake_c && (grant_src_c == SRC_ITLB);
  assign dtlb_miss_ready_o = handshake_c && (grant_src_c == SRC_DTLB);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_d       = resp_q;
    req_valid_d  = req_valid_q;
    drop_d       = drop_q;
    itlb_pulse_d = 1'b0;
    dtlb_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake_c) begin
          if (grant_src_c == SRC_ITLB) begin
            req_d.vpn  = VPN_WIDTH'(itlb_vpn_i);
            req_d.asid = ASID_WIDTH'(itlb_asid_i);
          end else begin
            req_d.vpn  = VPN_WIDTH'(dtlb_vpn_i);
            req_d.asid = ASID_WIDTH'(dtlb_asid_i);
          end
          req_d.src   = grant_src_c;
          req_valid_d = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (resp_live_c || timeout_c) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          // A flush seen anywhere in this lookup, including now, kills the result.
          if (!(drop_q || flush_i)) begin
            if (resp_live_c) begin
              resp_d.ppn    = PPN_WIDTH'(resp_ppn_i);
              resp_d.pgsize = pg_size_e'(resp_pgsize_i);
              resp_d.fault  = resp_fault_i;
            end else begin
              resp_d.ppn    = '0;
              resp_d.pgsize = PG_4K;
              resp_d.fault  = 1'b1;
            end
            itlb_pulse_d = (req_q.src == SRC_ITLB);
            dtlb_pulse_d = (req_q.src == SRC_DTLB);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TLB_MISS_TIMEOUT_EN
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    stale_d  = stale_q;
    if (state_q == ST_REQ)       wd_cnt_d = 32'd0;
    else if (state_q == ST_WAIT) wd_cnt_d = wd_cnt_q + 32'd1;
    if (resp_valid_i && (stale_q != 2'd0)) stale_d = stale_q - 2'd1;
    if (timeout_c && (stale_d != 2'd3))   stale_d = stale_d + 2'd1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      req_valid_q  <= 1'b0;
      drop_q       <= 1'b0;
      itlb_pulse_q <= 1'b0;
      dtlb_pulse_q <= 1'b0;
`ifdef TLB_MISS_TIMEOUT_EN
      wd_cnt_q     <= 32'd0;
      stale_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      req_valid_q  <= req_valid_d;
      drop_q       <= drop_d;
      itlb_pulse_q <= itlb_pulse_d;
      dtlb_pulse_q <= dtlb_pulse_d;
`ifdef TLB_MISS_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      stale_q      <= stale_d;
`endif
    end
  end

  assign req_valid_o       = req_valid_q;
  assign req_vpn_o         = VPN_W'(req_q.vpn);
  assign req_asid_o        = ASID_W'(req_q.asid);
  assign itlb_resp_valid_o = itlb_pulse_q;
  assign dtlb_resp_valid_o = dtlb_pulse_q;
  assign resp_ppn_o        = PPN_W'(resp_q.ppn);
  assign resp_pgsize_o     = resp_q.pgsize;
  assign resp_fault_o      = resp_q.fault;

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Self-checking bench for tlb_miss_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_tlb_miss_arbiter;

  localparam int unsigned VPN_W  = 27;
  localparam int unsigned PPN_W  = 44;
  localparam int unsigned ASID_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              itlb_miss_valid_i, itlb_miss_ready_o;
  logic [VPN_W-1:0]  itlb_vpn_i;
  logic [ASID_W-1:0] itlb_asid_i;
  logic              dtlb_miss_valid_i, dtlb_miss_ready_o;
  logic [VPN_W-1:0]  dtlb_vpn_i;
  logic [ASID_W-1:0] dtlb_asid_i;
  logic              req_valid_o, req_ready_i;
  logic [VPN_W-1:0]  req_vpn_o;
  logic [ASID_W-1:0] req_asid_o;
  logic              resp_valid_i;
  logic [PPN_W-1:0]  resp_ppn_i;
  logic [1:0]        resp_pgsize_i;
  logic              resp_fault_i;
  logic              itlb_resp_valid_o, dtlb_resp_valid_o;
  logic [PPN_W-1:0]  resp_ppn_o;
  logic [1:0]        resp_pgsize_o;
  logic              resp_fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tlb_miss_arbiter #(
    .VPN_W(VPN_W), .PPN_W(PPN_W), .ASID_W(ASID_W)
`ifdef TLB_MISS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .itlb_miss_valid_i(itlb_miss_valid_i), .itlb_miss_ready_o(itlb_miss_ready_o),
    .itlb_vpn_i(itlb_vpn_i), .itlb_asid_i(itlb_asid_i),
    .dtlb_miss_valid_i(dtlb_miss_valid_i), .dtlb_miss_ready_o(dtlb_miss_ready_o),
    .dtlb_vpn_i(dtlb_vpn_i), .dtlb_asid_i(dtlb_asid_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_vpn_o(req_vpn_o), .req_asid_o(req_asid_o),
    .resp_valid_i(resp_valid_i), .resp_ppn_i(resp_ppn_i),
    .resp_pgsize_i(resp_pgsize_i), .resp_fault_i(resp_fault_i),
    .itlb_resp_valid_o(itlb_resp_valid_o), .dtlb_resp_valid_o(dtlb_resp_valid_o),
    .resp_ppn_o(resp_ppn_o), .resp_pgsize_o(resp_pgsize_o), .resp_fault_o(resp_fault_o)
  );

  // Step to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0;
    itlb_miss_valid_i = 1'b0; itlb_vpn_i = '0; itlb_asid_i = '0;
    dtlb_miss_valid_i = 1'b0; dtlb_vpn_i = '0; dtlb_asid_i = '0;
    req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_ppn_i = '0; resp_pgsize_i = '0; resp_fault_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o, itlb_miss_ready_o,
         dtlb_miss_ready_o, resp_fault_o, resp_pgsize_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b ipulse=%b dpulse=%b irdy=%b drdy=%b fault=%b pg=%0d want all 0",
               req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o, itlb_miss_ready_o,
               dtlb_miss_ready_o, resp_fault_o, resp_pgsize_o);
    end
    checks++;
    if (resp_ppn_o !== '0) begin
      errors++; $display("FAIL reset_ppn got %h want 0", resp_ppn_o);
    end
  endtask

  task automatic test_single_itlb();
    do_reset();
    itlb_miss_valid_i = 1'b1; itlb_vpn_i = 27'h12345; itlb_asid_i = 16'd7;
    req_ready_i = 1'b1;
    #1;
    checks++;
    if ({itlb_miss_ready_o, dtlb_miss_ready_o} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b%b want 10", itlb_miss_ready_o, dtlb_miss_ready_o);
    end
    cyc();
    itlb_miss_valid_i = 1'b0;
    #1;
    checks++;
    if (req_valid_o !== 1'b1 || req_vpn_o !== 27'h12345 || req_asid_o !== 16'd7) begin
      errors++;
      $display("FAIL single_req got valid=%b vpn=%h asid=%0d want 1 12345 7", req_valid_o, req_vpn_o, req_asid_o);
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        resp_valid_i = 1'b1; resp_ppn_i = 44'hABCDE; resp_pgsize_i = 2'd0; resp_fault_i = 1'b0;
      end
      #1;
      checks++;
      if ({req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o} !== 3'b000) begin
        errors++;
        $display("FAIL single_wait%0d got req=%b ip=%b dp=%b want 000", k, req_valid_o,
                 itlb_resp_valid_o, dtlb_resp_valid_o);
      end
      cyc();
    end
    resp_valid_i = 1'b0;
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b10 || resp_ppn_o !== 44'hABCDE ||
        resp_pgsize_o !== 2'd0 || resp_fault_o !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got ip=%b dp=%b ppn=%h pg=%0d f=%b want 1 0 abcde 0 0",
               itlb_resp_valid_o, dtlb_resp_valid_o, resp_ppn_o, resp_pgsize_o, resp_fault_o);
    end
    cyc();
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b00 || resp_ppn_o !== 44'hABCDE) begin
      errors++;
      $display("FAIL single_hold got ip=%b dp=%b ppn=%h want 0 0 abcde",
               itlb_resp_valid_o, dtlb_resp_valid_o, resp_ppn_o);
    end
  endtask

  // Both sources hold requests; the shared TLB answers as fast as allowed.
  task automatic test_round_robin();
    int n_g, n_p;
    bit grant_d[4];
    bit pulse_d[4];
    do_reset();
    n_g = 0; n_p = 0;
    itlb_miss_valid_i = 1'b1; itlb_vpn_i = 27'h111; itlb_asid_i = 16'h1;
    dtlb_miss_valid_i = 1'b1; dtlb_vpn_i = 27'h222; dtlb_asid_i = 16'h2;
    req_ready_i = 1'b1; resp_valid_i = 1'b1; resp_ppn_i = 44'h5;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (itlb_miss_ready_o && dtlb_miss_ready_o) begin
        checks++; errors++; $display("FAIL rr_both_ready at cycle %0d got 11 want one-hot", c);
      end
      if (n_g < 4 && (itlb_miss_ready_o || dtlb_miss_ready_o)) begin
        grant_d[n_g] = dtlb_miss_ready_o; n_g++;
      end
      if (n_p < 4 && (itlb_resp_valid_o || dtlb_resp_valid_o)) begin
        pulse_d[n_p] = dtlb_resp_valid_o; n_p++;
      end
      cyc();
    end
    checks++;
    if (n_g != 4 || n_p != 4) begin
      errors++; $display("FAIL rr_progress got grants=%0d pulses=%0d want 4 4", n_g, n_p);
    end
    for (int i = 0; i < n_g; i++) begin
      checks++;
      if (grant_d[i] !== (i % 2 == 0)) begin
        errors++; $display("FAIL rr_grant%0d got dtlb=%b want %b", i, grant_d[i], (i % 2 == 0));
      end
    end
    for (int i = 0; i < n_p; i++) begin
      checks++;
      if (pulse_d[i] !== (i % 2 == 0)) begin
        errors++; $display("FAIL rr_pulse%0d got dtlb=%b want %b", i, pulse_d[i], (i % 2 == 0));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dtlb_miss_valid_i = 1'b1; dtlb_vpn_i = 27'h7654321; dtlb_asid_i = 16'h55;
    cyc();
    itlb_miss_valid_i = 1'b1; itlb_vpn_i = 27'h1;
    dtlb_vpn_i = 27'h3;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_valid_o !== 1'b1 || req_vpn_o !== 27'h7654321 || req_asid_o !== 16'h55 ||
          itlb_miss_ready_o !== 1'b0 || dtlb_miss_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got req=%b vpn=%h asid=%h irdy=%b drdy=%b want 1 7654321 55 0 0",
                 k, req_valid_o, req_vpn_o, req_asid_o, itlb_miss_ready_o, dtlb_miss_ready_o);
      end
      cyc();
    end
    req_ready_i = 1'b1;
    cyc();
    req_ready_i = 1'b0;
    #1;
    checks++;
    if (req_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_release got req=%b want 0", req_valid_o);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    itlb_miss_valid_i = 1'b1; itlb_vpn_i = 27'h3; req_ready_i = 1'b1;
    cyc();
    itlb_miss_valid_i = 1'b0;
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    resp_valid_i = 1'b1; resp_ppn_i = 44'h1; resp_fault_i = 1'b1;
    cyc();
    resp_valid_i = 1'b0; resp_fault_i = 1'b0;
    dtlb_miss_valid_i = 1'b1; dtlb_vpn_i = 27'h4AB; dtlb_asid_i = 16'h9;
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o, dtlb_miss_ready_o} !== 3'b001 ||
        resp_ppn_o !== '0 || resp_fault_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got ip=%b dp=%b drdy=%b ppn=%h f=%b want 0 0 1 0 0",
               itlb_resp_valid_o, dtlb_resp_valid_o, dtlb_miss_ready_o, resp_ppn_o, resp_fault_o);
    end
    cyc();
    dtlb_miss_valid_i = 1'b0;
    #1;
    checks++;
    if (req_valid_o !== 1'b1 || req_vpn_o !== 27'h4AB) begin
      errors++; $display("FAIL flush_next got req=%b vpn=%h want 1 4ab", req_valid_o, req_vpn_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dtlb_miss_valid_i = 1'b1; dtlb_vpn_i = 27'h42; req_ready_i = 1'b1;
    cyc();
    dtlb_miss_valid_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    cyc();
    resp_valid_i = 1'b1; resp_ppn_i = 44'h5A5A; resp_pgsize_i = 2'd2; resp_fault_i = 1'b1;
    cyc();
    resp_valid_i = 1'b0;
    #1;
    checks++;
    if ({req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o, resp_fault_o, resp_pgsize_o} !== 6'b0 ||
        resp_ppn_o !== '0) begin
      errors++;
      $display("FAIL rstmid got req=%b ip=%b dp=%b f=%b pg=%0d ppn=%h want all 0",
               req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o, resp_fault_o, resp_pgsize_o, resp_ppn_o);
    end
  endtask

  // Random traffic against a lookup-at-a-time model of the arbitration rules.
  task automatic test_random();
    bit iv, dv, last_d, cur_d, drop, exp_ri, exp_rd, exp_pi, exp_pd, exp_f;
    logic [VPN_W-1:0]  ivpn, dvpn, cur_vpn;
    logic [ASID_W-1:0] iasid, dasid, cur_asid;
    logic [PPN_W-1:0]  exp_ppn;
    logic [1:0]        exp_pg;
    int phase, lat, grants;
    do_reset();
    iv = 0; dv = 0; last_d = 0; cur_d = 0; drop = 0; exp_pi = 0; exp_pd = 0;
    exp_ppn = '0; exp_pg = '0; exp_f = 0; phase = 0; lat = 0; grants = 0;
    ivpn = '0; dvpn = '0; iasid = '0; dasid = '0; cur_vpn = '0; cur_asid = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!iv && $urandom_range(2) == 0) begin
        iv = 1; ivpn = 27'($urandom); iasid = 16'($urandom);
      end
      if (!dv && $urandom_range(2) == 0) begin
        dv = 1; dvpn = 27'($urandom); dasid = 16'($urandom);
      end
      itlb_miss_valid_i = iv; itlb_vpn_i = ivpn; itlb_asid_i = iasid;
      dtlb_miss_valid_i = dv; dtlb_vpn_i = dvpn; dtlb_asid_i = dasid;
      req_ready_i = ($urandom_range(3) != 0);
      flush_i = ($urandom_range(15) == 0);
      resp_valid_i = 1'b0;
      resp_ppn_i = {12'($urandom), 32'($urandom)};
      resp_pgsize_i = 2'($urandom_range(2));
      resp_fault_i = 1'($urandom);
      if (phase == 2) begin
        if (lat == 0) resp_valid_i = 1'b1;
        else lat--;
      end else if (phase == 0 && $urandom_range(7) == 0) begin
        resp_valid_i = 1'b1;
      end
      #1;
      exp_ri = (phase == 0) && iv && (!dv || last_d);
      exp_rd = (phase == 0) && dv && (!iv || !last_d);
      checks++;
      if ({itlb_miss_ready_o, dtlb_miss_ready_o} !== {exp_ri, exp_rd}) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b%b want %b%b", c,
                           itlb_miss_ready_o, dtlb_miss_ready_o, exp_ri, exp_rd);
      end
      checks++;
      if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== {exp_pi, exp_pd}) begin
        errors++; $display("FAIL rnd_pulse c=%0d got %b%b want %b%b", c,
                           itlb_resp_valid_o, dtlb_resp_valid_o, exp_pi, exp_pd);
      end
      checks++;
      if ({resp_ppn_o, resp_pgsize_o, resp_fault_o} !== {exp_ppn, exp_pg, exp_f}) begin
        errors++; $display("FAIL rnd_data c=%0d got %h/%0d/%b want %h/%0d/%b", c,
                           resp_ppn_o, resp_pgsize_o, resp_fault_o, exp_ppn, exp_pg, exp_f);
      end
      checks++;
      if (req_valid_o !== (phase == 1) ||
          (phase == 1 && (req_vpn_o !== cur_vpn || req_asid_o !== cur_asid))) begin
        errors++; $display("FAIL rnd_req c=%0d got %b %h %h want %b %h %h", c,
                           req_valid_o, req_vpn_o, req_asid_o, (phase == 1), cur_vpn, cur_asid);
      end
      exp_pi = 0; exp_pd = 0;
      if (phase != 0 && flush_i) drop = 1;
      if (phase == 2 && resp_valid_i) begin
        if (!drop) begin
          exp_pi = !cur_d; exp_pd = cur_d;
          exp_ppn = resp_ppn_i; exp_pg = resp_pgsize_i; exp_f = resp_fault_i;
        end
        phase = 0; drop = 0;
      end else if (phase == 1 && req_ready_i) begin
        phase = 2; lat = $urandom_range(4);
      end else if (exp_ri || exp_rd) begin
        phase = 1; cur_d = exp_rd; last_d = exp_rd; grants++;
        cur_vpn = exp_rd ? dvpn : ivpn;
        cur_asid = exp_rd ? dasid : iasid;
        if (exp_rd) dv = 0; else iv = 0;
      end
      cyc();
    end
    checks++;
    if (grants < 200) begin
      errors++; $display("FAIL rnd_progress got grants=%0d want >=200", grants);
    end
  endtask

`ifdef TLB_MISS_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    itlb_miss_valid_i = 1'b1; itlb_vpn_i = 27'h9; req_ready_i = 1'b1;
    cyc();
    itlb_miss_valid_i = 1'b0;
    cyc();
    for (int k = 0; k < 7; k++) begin
      #1;
      checks++;
      if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b00) begin
        errors++; $display("FAIL to_early%0d got %b%b want 00", k, itlb_resp_valid_o, dtlb_resp_valid_o);
      end
      cyc();
    end
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b10 || resp_fault_o !== 1'b1 || resp_ppn_o !== '0) begin
      errors++; $display("FAIL to_fire got ip=%b dp=%b f=%b ppn=%h want 1 0 1 0",
                         itlb_resp_valid_o, dtlb_resp_valid_o, resp_fault_o, resp_ppn_o);
    end
    cyc();
    resp_valid_i = 1'b1; resp_ppn_i = 44'h777;
    cyc();
    resp_valid_i = 1'b0;
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b00 || resp_ppn_o !== '0 || resp_fault_o !== 1'b1) begin
      errors++; $display("FAIL to_late got ip=%b dp=%b ppn=%h f=%b want 0 0 0 1",
                         itlb_resp_valid_o, dtlb_resp_valid_o, resp_ppn_o, resp_fault_o);
    end
    dtlb_miss_valid_i = 1'b1; dtlb_vpn_i = 27'hA;
    cyc();
    dtlb_miss_valid_i = 1'b0;
    cyc();
    resp_valid_i = 1'b1; resp_ppn_i = 44'h888; resp_pgsize_i = 2'd1; resp_fault_i = 1'b0;
    cyc();
    resp_valid_i = 1'b0;
    #1;
    checks++;
    if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b01 || resp_ppn_o !== 44'h888 ||
        resp_pgsize_o !== 2'd1 || resp_fault_o !== 1'b0) begin
      errors++; $display("FAIL to_next got ip=%b dp=%b ppn=%h pg=%0d f=%b want 0 1 888 1 0",
                         itlb_resp_valid_o, dtlb_resp_valid_o, resp_ppn_o, resp_pgsize_o, resp_fault_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_itlb();
    test_round_robin();
    test_backpressure();
    test_flush_wait();
    test_reset_mid();
    test_random();
`ifdef TLB_MISS_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
